// File: rtl/counter_pkg.sv
// Shared constants for the lab counter family: counting modes and the
// decimal display ranges the binary-to-BCD path is sized for.
package counter_pkg;

    localparam int MODE_SATURATE = 0;
    localparam int MODE_WRAP     = 1;

    localparam int DEC2_MAX = 99;
    localparam int DEC4_MAX = 9999;

endpackage : counter_pkg

// File: rtl/step_sync_edge.sv
// Brings an asynchronous, debounced button level into clk and emits one
// single-cycle pulse per rising edge. Shared by the button-driven lab blocks.
module step_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse_out
);

    if (SYNC_STAGES < 2) begin : g_chk_stages
        $fatal(1, "step_sync_edge: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse_out = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule : step_sync_edge

// File: rtl/updown_counter_param.sv
// Range-limited up/down counter stepped by a synchronised button, with
// wrap or saturate at the range ends, load, enable and boundary status.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MIN_VAL     = 0,
    parameter int MAX_VAL     = DEC2_MAX,
    parameter int RESET_VAL   = 0,
    parameter int WRAP        = MODE_WRAP,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_in,
    input  logic             up,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_pulse
);

    if (MIN_VAL > RESET_VAL || RESET_VAL > MAX_VAL) begin : g_chk_reset
        $fatal(1, "updown_counter_param: RESET_VAL outside [MIN_VAL, MAX_VAL]");
    end
    if (WIDTH < 63 && longint'(MAX_VAL) > ((64'sd1 <<< WIDTH) - 64'sd1)) begin : g_chk_width
        $fatal(1, "updown_counter_param: MAX_VAL does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

    logic             step;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    step_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_step_sync (
        .clk       (clk),
        .reset     (reset),
        .async_in  (step_in),
        .pulse_out (step)
    );

    // Steps only move the count strictly inside the range, so +/-1 never overflows.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            if (load_val <= MIN_W) begin
                count_d = MIN_W;
            end else if (load_val >= MAX_W) begin
                count_d = MAX_W;
            end else begin
                count_d = load_val;
            end
        end else if (step && enable) begin
            if (up) begin
                if (count_q < MAX_W) begin
                    count_d = count_q + 1'b1;
                end else if (WRAP == MODE_WRAP) begin
                    count_d = MIN_W;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (count_q > MIN_W) begin
                    count_d = count_q - 1'b1;
                end else if (WRAP == MODE_WRAP) begin
                    count_d = MAX_W;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RESET_W;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count      = count_q;
    assign wrap_pulse = wrap_q;
    assign at_max     = (count_q == MAX_W);
    assign at_min     = (count_q == MIN_W);

endmodule : updown_counter_param

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench: three counter configurations share one stimulus stream;
// a spec-level model queues expected state per edge, a monitor compares it.
module tb_updown_counter_param;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        step_in, up, enable, load;
    logic [13:0] load_val;

    logic [7:0]  cnt_a, cnt_s;
    logic [13:0] cnt_w;
    logic        amax_a, amin_a, wp_a;
    logic        amax_s, amin_s, wp_s;
    logic        amax_w, amin_w, wp_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    updown_counter_param dut_a (
        .clk(clk), .reset(reset), .step_in(step_in), .up(up), .enable(enable),
        .load(load), .load_val(load_val[7:0]), .count(cnt_a),
        .at_max(amax_a), .at_min(amin_a), .wrap_pulse(wp_a)
    );

    updown_counter_param #(.WRAP(0)) dut_s (
        .clk(clk), .reset(reset), .step_in(step_in), .up(up), .enable(enable),
        .load(load), .load_val(load_val[7:0]), .count(cnt_s),
        .at_max(amax_s), .at_min(amin_s), .wrap_pulse(wp_s)
    );

    updown_counter_param #(.WIDTH(14), .MIN_VAL(10), .MAX_VAL(9999), .RESET_VAL(10)) dut_w (
        .clk(clk), .reset(reset), .step_in(step_in), .up(up), .enable(enable),
        .load(load), .load_val(load_val), .count(cnt_w),
        .at_max(amax_w), .at_min(amin_w), .wrap_pulse(wp_w)
    );

    // Reference configurations: index 0 = wrap 0..99, 1 = saturate 0..99, 2 = wrap 10..9999 (14 bit)
    int cfg_mask [3] = '{255, 255, 16383};
    int cfg_min  [3] = '{0, 0, 10};
    int cfg_max  [3] = '{99, 99, 9999};
    int cfg_rst  [3] = '{0, 0, 10};
    int cfg_wrap [3] = '{1, 0, 1};

    typedef struct {
        int c0, c1, c2;
        bit w0, w1, w2;
    } exp_t;

    exp_t q[$];
    int   mc [3];
    bit   mw [3];
    bit   hist [SYNC+1];

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // hist[i] holds step_in as sampled i+1 edges ago; a step reaches the counter
    // SYNC edges after its rising edge is first sampled.
    always @(posedge clk or negedge reset) begin
        exp_t e;
        bit   stp;
        int   v;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                mc[i] = cfg_rst[i];
                mw[i] = 1'b0;
            end
            for (int i = 0; i <= SYNC; i++) hist[i] = 1'b0;
            q.delete();
        end else begin
            stp = hist[SYNC-1] && !hist[SYNC];
            for (int i = 0; i < 3; i++) begin
                mw[i] = 1'b0;
                if (load) begin
                    v = int'(load_val) & cfg_mask[i];
                    mc[i] = (v < cfg_min[i]) ? cfg_min[i] : (v > cfg_max[i]) ? cfg_max[i] : v;
                end else if (stp && enable) begin
                    if (up) begin
                        if (mc[i] < cfg_max[i]) mc[i] = mc[i] + 1;
                        else if (cfg_wrap[i] == 1) begin mc[i] = cfg_min[i]; mw[i] = 1'b1; end
                    end else begin
                        if (mc[i] > cfg_min[i]) mc[i] = mc[i] - 1;
                        else if (cfg_wrap[i] == 1) begin mc[i] = cfg_max[i]; mw[i] = 1'b1; end
                    end
                end
            end
            for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = step_in;
        end
        e.c0 = mc[0]; e.c1 = mc[1]; e.c2 = mc[2];
        e.w0 = mw[0]; e.w1 = mw[1]; e.w2 = mw[2];
        q.push_back(e);
    end

    task automatic cmp_dut(input string nm, input int idx, input int c, input bit mx,
                           input bit mn, input bit w, input int ec, input bit ew);
        cmp({nm, ".count"}, c, ec);
        cmp({nm, ".at_max"}, int'(mx), int'(ec == cfg_max[idx]));
        cmp({nm, ".at_min"}, int'(mn), int'(ec == cfg_min[idx]));
        cmp({nm, ".wrap_pulse"}, int'(w), int'(ew));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp_dut("wrap",  0, int'(cnt_a), amax_a, amin_a, wp_a, e.c0, e.w0);
            cmp_dut("sat",   1, int'(cnt_s), amax_s, amin_s, wp_s, e.c1, e.w1);
            cmp_dut("wide",  2, int'(cnt_w), amax_w, amin_w, wp_w, e.c2, e.w2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse();
        step_in = 1'b1;
        repeat (3) tick();
        step_in = 1'b0;
        repeat (2) tick();
    endtask

    task automatic do_load(input int v);
        load_val = 14'(v);
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; step_in = 1'b0; up = 1'b1; enable = 1'b1; load = 1'b0; load_val = '0;
        repeat (3) tick();
        cmp("rst.count", int'(cnt_a), 0);
        cmp("rst.at_min", int'(amin_a), 1);
        cmp("rst.at_max", int'(amax_a), 0);
        cmp("rst.wrap_pulse", int'(wp_a), 0);
        cmp("rst.wide_count", int'(cnt_w), 10);
        reset = 1'b1;
        repeat (2) tick();

        step_in = 1'b1;
        tick(); cmp("lat.edge1", int'(cnt_a), 0);
        tick(); cmp("lat.edge2", int'(cnt_a), 0);
        tick(); cmp("lat.edge3", int'(cnt_a), 1);
        repeat (47) tick();
        cmp("hold50.count", int'(cnt_a), 1);
        step_in = 1'b0;
        repeat (2) tick();
        repeat (9) pulse();
        cmp("ten_pulses.count", int'(cnt_a), 10);
        cmp("ten_pulses.wide", int'(cnt_w), 20);

        do_load(99);
        cmp("load99.count", int'(cnt_a), 99);
        cmp("load99.at_max", int'(amax_a), 1);
        step_in = 1'b1;
        repeat (3) tick();
        cmp("wrap_up.count", int'(cnt_a), 0);
        cmp("wrap_up.pulse", int'(wp_a), 1);
        cmp("sat_up.count", int'(cnt_s), 99);
        tick();
        cmp("wrap_up.pulse_end", int'(wp_a), 0);
        step_in = 1'b0;
        repeat (2) tick();

        up = 1'b0;
        step_in = 1'b1;
        repeat (3) tick();
        cmp("wrap_dn.count", int'(cnt_a), 99);
        cmp("wrap_dn.pulse", int'(wp_a), 1);
        step_in = 1'b0;
        tick();
        cmp("wrap_dn.pulse_end", int'(wp_a), 0);
        tick();

        do_load(99);
        up = 1'b1;
        repeat (3) pulse();
        cmp("sat_max.count", int'(cnt_s), 99);
        cmp("sat_max.at_max", int'(amax_s), 1);
        do_load(0);
        up = 1'b0;
        pulse();
        cmp("sat_min.count", int'(cnt_s), 0);
        cmp("sat_min.at_min", int'(amin_s), 1);

        do_load(200);
        cmp("load200.count", int'(cnt_a), 99);
        cmp("load200.wide", int'(cnt_w), 200);
        up = 1'b1;
        step_in = 1'b1;
        repeat (2) tick();
        load_val = 14'd5;
        load = 1'b1;
        tick();
        load = 1'b0;
        step_in = 1'b0;
        cmp("load_vs_step.count", int'(cnt_a), 5);
        repeat (3) tick();
        cmp("load_vs_step.after", int'(cnt_a), 5);

        enable = 1'b0;
        repeat (4) pulse();
        cmp("disabled.count", int'(cnt_a), 5);
        enable = 1'b1;

        step_in = 1'b1;
        tick();
        reset = 1'b0;
        step_in = 1'b0;
        tick();
        reset = 1'b1;
        repeat (5) tick();
        cmp("rst_mid_sync.count", int'(cnt_a), 0);
        cmp("rst_mid_sync.wide", int'(cnt_w), 10);

        up = 1'b0;
        step_in = 1'b1;
        repeat (3) tick();
        cmp("wide_wrap_dn.count", int'(cnt_w), 9999);
        cmp("wide_wrap_dn.pulse", int'(wp_w), 1);
        step_in = 1'b0;
        repeat (2) tick();

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) step_in = ~step_in;
            up     = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 5) != 0);
            load   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 0) load_val = 14'($urandom_range(0, 255));
            else                            load_val = 14'($urandom_range(9980, 16383));
            tick();
        end
        load = 1'b0;
        step_in = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_updown_counter_param

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised up/down counter: the next generation of the lab up/down counter.
- Runs on a single system clock; the user step button is sampled asynchronously, synchronised, and edge-detected internally. No second clock domain is required.
- Adds programmable range, wrap or saturate mode, count enable, synchronous load, and boundary/wrap status.
- Binary count output feeds the existing binary-to-BCD and 4-digit seven-segment display path unchanged.

Parameters:
- WIDTH, 8: counter width in bits.
- MIN_VAL, 0: lowest count value.
- MAX_VAL, 99: highest count value.
- RESET_VAL, 0: count value after reset.
- WRAP, 1: 1 = wrap at range ends; 0 = saturate at range ends.
- SYNC_STAGES, 2: flip-flop stages in the step_in synchroniser; minimum 2.

Ports:
- clk  in  1: system clock; all state is on its rising edge.
- reset  in  1: asynchronous, active-low reset.
- step_in  in  1: asynchronous user step request (button/switch), already debounced.
- up  in  1: direction; 1 = increment, 0 = decrement. Sampled on the cycle the step is applied.
- enable  in  1: count enable; steps are ignored while low.
- load  in  1: synchronous load strobe.
- load_val  in  WIDTH: value loaded when load=1.
- count  out  WIDTH: current count (registered).
- at_max  out  1: high while count == MAX_VAL.
- at_min  out  1: high while count == MIN_VAL.
- wrap_pulse  out  1: one-cycle pulse on the cycle after a wrap occurs.

Behaviour:
- Reset (reset=0, asynchronous):
  - count = RESET_VAL, wrap_pulse = 0.
  - Synchroniser chain and edge-detect register cleared to 0.
  - at_max/at_min reflect RESET_VAL.
  - Release is synchronous to clk in use; the block needs no reset-release sequencing.
- Synchroniser: step_in passes through SYNC_STAGES flops. Internal step = last stage & ~previous last stage, i.e. one cycle per rising edge of step_in.
- Step latency: with step_in held high, count changes on the (SYNC_STAGES+1)th rising clk edge after the first edge that samples step_in high. For the default, that is the 3rd edge.
- Holding step_in high produces exactly one step. A new step requires step_in low for at least one sampled cycle, then high again.
- Priority per cycle: load > step.
  - load=1: count <= load_val, clamped into [MIN_VAL, MAX_VAL] (below MIN -> MIN, above MAX -> MAX). Any coincident step is discarded, not deferred. load works regardless of enable.
  - step=1, enable=1, up=1:
    - count < MAX_VAL: count + 1.
    - count == MAX_VAL and WRAP=1: count <= MIN_VAL, wrap_pulse=1 next cycle.
    - count == MAX_VAL and WRAP=0: hold, no pulse.
  - step=1, enable=1, up=0:
    - count > MIN_VAL: count - 1.
    - count == MIN_VAL and WRAP=1: count <= MAX_VAL, wrap_pulse=1.
    - count == MIN_VAL and WRAP=0: hold.
  - step=1, enable=0: step dropped, count holds.
- Arithmetic: all comparisons unsigned at WIDTH bits; no intermediate result exceeds the WIDTH range, because increment/decrement happen only strictly inside the range.
- at_max/at_min: decoded combinationally from the count register, so they are glitch-free relative to clk. Both are high when MIN_VAL == MAX_VAL.
- wrap_pulse: registered, high exactly one cycle per wrap event, low otherwise; never asserted by load.
- Reset asserted mid-step (during synchronisation): the pending step is lost; count = RESET_VAL.
- Elaboration checks (fatal on violation):
  - MIN_VAL <= RESET_VAL <= MAX_VAL.
  - MAX_VAL <= 2^WIDTH - 1.
  - SYNC_STAGES >= 2.

Decomposition:
- Shared package counter_pkg holds:
  - Mode constants MODE_SATURATE = 0, MODE_WRAP = 1.
  - Default range constants for the decimal display: DEC2_MAX = 99, DEC4_MAX = 9999.
- One sub-module, step_sync_edge:
  - Parameter SYNC_STAGES; ports clk, reset, async_in, pulse_out.
  - Reused by other button-driven lab blocks.

Test Plan:
- Reset: reset=0 with defaults -> count=0, at_min=1, at_max=0, wrap_pulse=0. Release, then one step_in pulse with up=1 -> count=1 exactly on the 3rd clk edge after step_in is sampled high.
- Hold step_in high 50 cycles, up=1 -> count increments once only (0 -> 1); 10 separated pulses -> count=10.
- Wrap mode:
  - load 99, step up -> count=0, wrap_pulse high 1 cycle.
  - Step down -> count=99, wrap_pulse high 1 cycle.
- WRAP=0 (saturate):
  - At 99, 3 up steps -> count stays 99, at_max=1, no wrap_pulse.
  - At 0, down step -> stays 0.
- Load and enable:
  - load_val=200 -> count=99; load_val=5 with a coincident step -> count=5 (step discarded).
  - enable=0 with 4 steps -> count unchanged.
- Reset during sync: assert reset 1 cycle after step_in rises -> count=RESET_VAL, no later increment. Repeat with WIDTH=14, MAX_VAL=9999, MIN_VAL=10, RESET_VAL=10: step down at 10 wraps to 9999.
